// File: rtl/serial_mag_cmp.sv
// Bit-serial LSB-first unsigned magnitude comparator with cascade seeds and valid/ready handshakes.
// Result appears N edges after acceptance; DONE holds until out_ready. Optional lt output under SERIAL_MAG_CMP_LT_EN.
module serial_mag_cmp #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         eq_in,
    input  logic         gt_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         eq,
    output logic         gt,
`ifdef SERIAL_MAG_CMP_LT_EN
    output logic         lt,
`endif
    output logic         busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  sa_q, sa_d;
    logic [N-1:0]  sb_q, sb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          eq_q, eq_d;
    logic          gt_q, gt_d;
`ifdef SERIAL_MAG_CMP_LT_EN
    logic          lt_q;
`endif

    assign in_ready  = (state_q == S_IDLE) & rst_n;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign eq        = eq_q;
    assign gt        = gt_q;
`ifdef SERIAL_MAG_CMP_LT_EN
    assign lt        = lt_q;
`endif

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sa_d    = a;
                    sb_d    = b;
                    eq_d    = eq_in;
                    // An equal lower chunk cannot also be greater.
                    gt_d    = gt_in & ~eq_in;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Walking upward, any differing bit overrides everything below it.
                if (sa_q[0] != sb_q[0]) begin
                    eq_d = 1'b0;
                    gt_d = sa_q[0] & ~sb_q[0];
                end
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

`ifdef SERIAL_MAG_CMP_LT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lt_q <= 1'b0;
        end else begin
            lt_q <= ~eq_d & ~gt_d;
        end
    end
`endif

    a_eq_gt_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(eq_q && gt_q));

endmodule
